// File: rtl/adc128s_pkg.sv
// ---------------------------------------------------------------------------
// adc128s_pkg
// Shared constants, types and helpers for the ADC128S-style SPI slave model.
//   FRAME_BITS      : SCLK rising edges in one complete frame
//   ch_t            : 3-bit channel address
//   CH_LFT/RGHT/BATT: channels that return the load-cell / battery values
//   LFSR_SEED/TAPS  : dither LFSR (x^16+x^14+x^13+x^11+1); used only when
//                     ADC128S_DITHER_EN is defined
// ---------------------------------------------------------------------------
package adc128s_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  typedef logic [CNT_W-1:0] bit_cnt_t;
  typedef logic [2:0]       ch_t;

  localparam bit_cnt_t FRAME_CNT = bit_cnt_t'(FRAME_BITS);

  localparam ch_t CH_LFT  = 3'd0;
  localparam ch_t CH_RGHT = 3'd4;
  localparam ch_t CH_BATT = 3'd5;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Taps at bit positions 16,14,13,11 (1-based) -> bits 15,13,12,10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Conversion result for a channel; unmapped channels read as zero.
  function automatic logic [11:0] ch_value(input ch_t         ch,
                                           input logic [11:0] lft,
                                           input logic [11:0] rght,
                                           input logic [11:0] batt);
    logic [11:0] v;
    v = 12'h000;
    case (ch)
      CH_LFT:  v = lft;
      CH_RGHT: v = rght;
      CH_BATT: v = batt;
      default: v = 12'h000;
    endcase
    return v;
  endfunction

  // Fibonacci step: feedback is the parity of the tapped bits.
  function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
    return {cur[14:0], ^(cur & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/spi_edge_sync.sv
// ---------------------------------------------------------------------------
// spi_edge_sync
// Brings SS_n, SCLK and MOSI into the clk domain through SYNC_STAGES flops
// and produces single-cycle edge pulses from the synchronized levels.
//   clk, rst_n    : system clock, synchronous active-low reset
//   i_ss_n/i_sclk/i_mosi : raw asynchronous SPI inputs
//   o_ss_n        : synchronized slave select level
//   o_ss_fall/rise: synchronized SS_n edge pulses
//   o_in_frame    : SS_n was low on the previous synchronized cycle
//   o_sclk_rise/fall : synchronized SCLK edge pulses
//   o_mosi        : synchronized MOSI
// ---------------------------------------------------------------------------
module spi_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ss_n,
  input  logic i_sclk,
  input  logic i_mosi,
  output logic o_ss_n,
  output logic o_ss_fall,
  output logic o_ss_rise,
  output logic o_in_frame,
  output logic o_sclk_rise,
  output logic o_sclk_fall,
  output logic o_mosi
);

  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_ss_prev;
  logic                   r_sclk_prev;
  logic                   w_ss;
  logic                   w_sclk;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      // Idle bus: deselected, SCLK high.
      r_ss_sync   <= {SYNC_STAGES{1'b1}};
      r_sclk_sync <= {SYNC_STAGES{1'b1}};
      r_mosi_sync <= '0;
      r_ss_prev   <= 1'b1;
      r_sclk_prev <= 1'b1;
    end else begin
      r_ss_sync[0]   <= i_ss_n;
      r_sclk_sync[0] <= i_sclk;
      r_mosi_sync[0] <= i_mosi;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_ss_sync[i]   <= r_ss_sync[i-1];
        r_sclk_sync[i] <= r_sclk_sync[i-1];
        r_mosi_sync[i] <= r_mosi_sync[i-1];
      end
      r_ss_prev   <= w_ss;
      r_sclk_prev <= w_sclk;
    end
  end

  always_comb begin
    w_ss        = r_ss_sync[SYNC_STAGES-1];
    w_sclk      = r_sclk_sync[SYNC_STAGES-1];
    o_ss_n      = w_ss;
    o_ss_fall   = r_ss_prev & ~w_ss;
    o_ss_rise   = ~r_ss_prev & w_ss;
    // Still true on the cycle SS_n rise is seen, so a coincident SCLK rise
    // is sampled before the frame-end decision.
    o_in_frame  = ~r_ss_prev;
    o_sclk_rise = ~r_sclk_prev & w_sclk;
    o_sclk_fall = r_sclk_prev & ~w_sclk;
    o_mosi      = r_mosi_sync[SYNC_STAGES-1];
  end

endmodule

// File: rtl/adc128s_spi_model.sv
// ---------------------------------------------------------------------------
// adc128s_spi_model
// Synthesizable model of an 8-channel 12-bit SPI A2D (ADC128S-style) slave.
// Pipelined: the channel addressed in frame N is returned in frame N+1.
// SPI mode: SCLK idles high, MOSI sampled on SCLK rise, MISO advanced on fall.
// Optional: define ADC128S_DITHER_EN to XOR an LFSR bit into result bit 0;
// the LFSR advances once per completed frame.
//   clk, rst_n    : system clock, synchronous active-low reset
//   SS_n, SCLK, MOSI : SPI inputs from the master (asynchronous to clk)
//   MISO          : serial conversion data, 0 while deselected
//   lft_cell_set, rght_cell_set, batt_set : 12-bit values per channel
// SCLK must run slower than clk/8.
// ---------------------------------------------------------------------------
module adc128s_spi_model
  import adc128s_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        SS_n,
  input  logic        SCLK,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [11:0] lft_cell_set,
  input  logic [11:0] rght_cell_set,
  input  logic [11:0] batt_set
);

  logic w_ss_n;
  logic w_ss_fall;
  logic w_ss_rise;
  logic w_in_frame;
  logic w_sclk_rise;
  logic w_sclk_fall;
  logic w_mosi;

  spi_edge_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_ss_n      (SS_n),
    .i_sclk      (SCLK),
    .i_mosi      (MOSI),
    .o_ss_n      (w_ss_n),
    .o_ss_fall   (w_ss_fall),
    .o_ss_rise   (w_ss_rise),
    .o_in_frame  (w_in_frame),
    .o_sclk_rise (w_sclk_rise),
    .o_sclk_fall (w_sclk_fall),
    .o_mosi      (w_mosi)
  );

  logic [15:0] r_rx_shift;
  logic [15:0] r_tx_shift;
  bit_cnt_t    r_bit_cnt;
  ch_t         r_pend_ch;

  logic [15:0] w_rx_shift_nxt;
  logic [15:0] w_tx_shift_nxt;
  bit_cnt_t    w_bit_cnt_nxt;
  ch_t         w_pend_ch_nxt;
  logic        w_frame_done;
  logic [11:0] w_load_val;

`ifdef ADC128S_DITHER_EN
  logic [15:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_SEED;
    end else if (w_frame_done) begin
      r_lfsr <= lfsr_next(r_lfsr);
    end
  end

  always_comb begin
    w_load_val    = ch_value(r_pend_ch, lft_cell_set, rght_cell_set, batt_set);
    w_load_val[0] = w_load_val[0] ^ r_lfsr[0];
  end
`else
  always_comb begin
    w_load_val = ch_value(r_pend_ch, lft_cell_set, rght_cell_set, batt_set);
  end
`endif

  always_comb begin
    w_rx_shift_nxt = r_rx_shift;
    w_tx_shift_nxt = r_tx_shift;
    w_bit_cnt_nxt  = r_bit_cnt;
    w_pend_ch_nxt  = r_pend_ch;
    w_frame_done   = 1'b0;

    if (w_ss_fall) begin
      // Set inputs are captured only here; later changes wait a frame.
      w_tx_shift_nxt = {4'b0000, w_load_val};
      w_bit_cnt_nxt  = '0;
    end else if (w_in_frame) begin
      // Bits beyond a full frame are dropped; the count saturates.
      if (w_sclk_rise && (r_bit_cnt < FRAME_CNT)) begin
        w_rx_shift_nxt = {r_rx_shift[14:0], w_mosi};
        w_bit_cnt_nxt  = r_bit_cnt + 1'b1;
      end
      // The fall preceding the first rise must not disturb the MSB.
      if (w_sclk_fall && (r_bit_cnt != '0)) begin
        w_tx_shift_nxt = {r_tx_shift[14:0], 1'b0};
      end
      // Uses next-state values so a coincident SCLK rise is counted first.
      if (w_ss_rise && (w_bit_cnt_nxt == FRAME_CNT)) begin
        w_pend_ch_nxt = w_rx_shift_nxt[13:11];
        w_frame_done  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rx_shift <= '0;
      r_tx_shift <= '0;
      r_bit_cnt  <= '0;
      r_pend_ch  <= CH_LFT;
    end else begin
      r_rx_shift <= w_rx_shift_nxt;
      r_tx_shift <= w_tx_shift_nxt;
      r_bit_cnt  <= w_bit_cnt_nxt;
      r_pend_ch  <= w_pend_ch_nxt;
    end
  end

  always_comb begin
    MISO = ~w_ss_n & r_tx_shift[15];
  end

endmodule

// File: tb/tb_adc128s_spi_model.sv
module tb_adc128s_spi_model;

  logic        clk;
  logic        rst_n;
  logic        SS_n;
  logic        SCLK;
  logic        MOSI;
  logic        MISO;
  logic [11:0] lft_cell_set;
  logic [11:0] rght_cell_set;
  logic [11:0] batt_set;

  int          n_tests;
  int          n_fail;
  logic [15:0] q_exp[$];

  adc128s_spi_model #(
    .SYNC_STAGES (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .SS_n          (SS_n),
    .SCLK          (SCLK),
    .MOSI          (MOSI),
    .MISO          (MISO),
    .lft_cell_set  (lft_cell_set),
    .rght_cell_set (rght_cell_set),
    .batt_set      (batt_set)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One SPI frame of nbits SCLK cycles. MOSI is 1 beyond bit 15.
  // chg_bit >= 0 rewrites rght_cell_set just before that bit's SCLK fall.
  task automatic spi_frame(input string tag, input logic [15:0] cmd, input int nbits,
                           input bit chk, input logic [15:0] exp,
                           input int chg_bit, input logic [11:0] chg_val);
    logic [15:0] got;
    logic        extra;
    logic [15:0] e;
    got   = '0;
    extra = 1'b0;
    if (chk) q_exp.push_back(exp);
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < nbits; i++) begin
      if (i == chg_bit) rght_cell_set = chg_val;
      SCLK = 1'b0;
      MOSI = (i < 16) ? cmd[15-i] : 1'b1;
      wait_clk(7);
      if (i < 16) got[15-i] = MISO;
      else        extra = extra | MISO;
      wait_clk(1);
      SCLK = 1'b1;
      wait_clk(8);
    end
    SS_n = 1'b1;
    MOSI = 1'b0;
    wait_clk(8);
    if (chk) begin
      if (q_exp.size() == 0) begin
        check({tag, "_queue_empty"}, 16'd0, 16'd1);
      end else begin
        e = q_exp.pop_front();
        check(tag, got, e);
        if (nbits > 16) check({tag, "_extra"}, {15'd0, extra}, 16'd0);
      end
    end
  endtask

  initial begin
    n_tests       = 0;
    n_fail        = 0;
    rst_n         = 1'b0;
    SS_n          = 1'b1;
    SCLK          = 1'b1;
    MOSI          = 1'b0;
    lft_cell_set  = 12'h3A5;
    rght_cell_set = 12'h123;
    batt_set      = 12'hABC;

    wait_clk(3);
    check("reset_miso", {15'd0, MISO}, 16'd0);
    rst_n = 1'b1;
    wait_clk(4);
    check("idle_miso", {15'd0, MISO}, 16'd0);

    // pend_ch resets to channel 0.
    spi_frame("rst_ch0", 16'h0000, 16, 1'b1, 16'h03A5, -1, 12'h0);
    // Address ch4, then ch5 -> second returns rght.
    spi_frame("addr_ch4", 16'h2000, 16, 1'b1, 16'h03A5, -1, 12'h0);
    spi_frame("ret_rght", 16'h2800, 16, 1'b1, 16'h0123, -1, 12'h0);
    // ch5 pending -> batt; then ch2 (unmapped) -> 0.
    spi_frame("ret_batt", 16'h1000, 16, 1'b1, 16'h0ABC, -1, 12'h0);
    spi_frame("ret_unmap", 16'h0000, 16, 1'b1, 16'h0000, -1, 12'h0);

    // Mid-frame change of rght_cell_set does not affect the current frame.
    rght_cell_set = 12'h111;
    spi_frame("addr_ch4b", 16'h2000, 16, 1'b1, 16'h03A5, -1, 12'h0);
    spi_frame("mid_change", 16'h2800, 16, 1'b1, 16'h0111, 8, 12'h222);

    // ch5 pending; aborted ch0 frame leaves it pending.
    spi_frame("abort", 16'h0000, 8, 1'b0, 16'h0000, -1, 12'h0);
    spi_frame("post_abort", 16'h2000, 16, 1'b1, 16'h0ABC, -1, 12'h0);

    // ch4 pending; reset mid-frame returns pend_ch to 0.
    SS_n = 1'b0;
    wait_clk(8);
    for (int i = 0; i < 8; i++) begin
      SCLK = 1'b0;
      MOSI = 1'b1;
      wait_clk(8);
      SCLK = 1'b1;
      wait_clk(8);
    end
    rst_n = 1'b0;
    SS_n  = 1'b1;
    MOSI  = 1'b0;
    wait_clk(1);
    check("midrst_miso0", {15'd0, MISO}, 16'd0);
    wait_clk(2);
    check("midrst_miso1", {15'd0, MISO}, 16'd0);
    rst_n = 1'b1;
    wait_clk(6);
    check("midrst_idle", {15'd0, MISO}, 16'd0);
    spi_frame("post_rst", 16'h2000, 20, 1'b1, 16'h03A5, -1, 12'h0);
    // Extra MOSI ones above were ignored, so ch4 is pending.
    spi_frame("post_extra", 16'h0000, 16, 1'b1, 16'h0222, -1, 12'h0);
    check("queue_drained", 16'(q_exp.size()), 16'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/adc128s_spi_model.md
Name: adc128s_spi_model

Overview:
- Synthesizable behavioral model of an 8-channel, 12-bit SPI A2D converter (ADC128S-style).
- Sits in the bench/system as the SPI slave behind the Segway A2D interface.
- Returns left-load-cell, right-load-cell and battery readings supplied as 12-bit input values.
- Follows pipelined ADC128S protocol: channel addressed in frame N is returned in frame N+1.

Parameters:
- FRAME_BITS, 16, SCLK edges per frame.
- SYNC_STAGES, 2, flop stages synchronizing SS_n/SCLK/MOSI into clk domain.
- CH_LFT, 3'd0, channel returning lft_cell_set.
- CH_RGHT, 3'd4, channel returning rght_cell_set.
- CH_BATT, 3'd5, channel returning batt_set.

Ports:
- clk  input  1  system clock; only clock in the block.
- rst_n  input  1  synchronous active-low reset.
- SS_n  input  1  SPI slave select, active low.
- SCLK  input  1  SPI clock; idles high.
- MOSI  input  1  serial command from master.
- MISO  output  1  serial conversion data to master.
- lft_cell_set  input  12  value reported on CH_LFT.
- rght_cell_set  input  12  value reported on CH_RGHT.
- batt_set  input  12  value reported on CH_BATT.

Behaviour:
- Reset is sampled on rising clk with rst_n low. All synchronizers are set to idle (SS_n=1, SCLK=1). rx_shift=0, tx_shift=0, bit_cnt=0, pend_ch=0. MISO=0.
- SPI mode: SCLK idles high. Slave samples MOSI on SCLK rise and advances MISO on SCLK fall.
- All edges are detected from synchronized signals, registered against their previous value. SCLK from the master must be slower than clk/8.
- Frame start: on synchronized SS_n falling edge, tx_shift is loaded with {4'b0, value(pend_ch)}, and bit_cnt is cleared.
  - value(ch) = lft_cell_set / rght_cell_set / batt_set per CH_* mapping, else 12'h000.
  - Set inputs are sampled only at this instant. Later changes do not affect the current frame.
- MISO = tx_shift[15] while SS_n low, else 0. The first bit is valid one cycle after the SS_n fall is detected.
- On each SCLK rise while SS_n low, MOSI is shifted into rx_shift LSB and bit_cnt increments, saturating at FRAME_BITS.
- On each SCLK fall while SS_n low and bit_cnt != 0, tx_shift shifts left with 0 fill.
- Frame end: on SS_n rising edge with bit_cnt == FRAME_BITS, pend_ch is set to rx_shift[13:11]. Other command bits are ignored.
- Abort: SS_n rises with bit_cnt < FRAME_BITS. pend_ch is unchanged and the frame is discarded.
- More than FRAME_BITS SCLK rises: extra MOSI bits are ignored and MISO shifts out 0s.
- SCLK edges while SS_n high are ignored.
- Simultaneous SS_n rise and SCLK rise in the same cycle: the SCLK sample is taken first, then frame-end evaluation.
- Reset mid-frame: the frame is abandoned and pend_ch=0. The next frame returns channel 0.
- Back-to-back frames (SS_n high for ≥1 synchronized cycle) are supported. No minimum idle beyond that.

Optional Feature:
- Macro: ADC128S_DITHER_EN.
- Defined: a 16-bit LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 at reset) advances once per completed frame. Its bit 0 is XORed into bit 0 of the loaded 12-bit value.
- Undefined: values are returned exactly; no LFSR logic is present.

Decomposition:
- Package adc128s_pkg holds:
  - FRAME_BITS;
  - channel typedef logic [2:0];
  - CH_LFT/CH_RGHT/CH_BATT constants;
  - LFSR seed/taps.
- One natural sub-module, spi_edge_sync: SYNC_STAGES synchronizer plus rise/fall pulse generation for SS_n and SCLK, and synchronized MOSI.

Test Plan:
- Reset, lft_cell_set=12'h3A5, one frame with cmd 16'h0000 -> MISO word 16'h03A5, because pend_ch resets to 0.
- Frame cmd 16'h2000 (ch4), then frame cmd 16'h2800 with rght_cell_set=12'h123 -> second frame returns 16'h0123.
- Frame cmd ch5, then frame cmd ch2 with batt_set=12'hABC -> returns 16'h0ABC. Third frame returns 16'h0000 (ch2 unmapped).
- Address ch4, start next frame, change rght_cell_set from 12'h111 to 12'h222 mid-frame -> returns 16'h0111.
- Address ch5, then abort a ch0 frame after 8 SCLKs -> next full frame still returns batt_set.
- Assert rst_n low mid-frame after addressing ch4 -> MISO=0 during reset. Next frame returns lft_cell_set (ch0).
